// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types and constants.
//   memory_word_t : result data word
//   cdb_t         : broadcast bus payload {tag, value}; tag 0 marks an idle bus
//   REQ_*         : requester index of each functional unit
//   outranks()    : priority compare used by the age selector
package cdb_arbiter_pkg;

    localparam int unsigned ROB_SIZE_DEF     = 16;
    localparam int unsigned TAG_W            = 8;
    localparam int unsigned WORD_W           = 32;
    localparam int unsigned NUM_REQ_DEF      = 4;
    localparam int unsigned STARVE_LIMIT_DEF = 8;

    localparam int unsigned REQ_ALU0   = 0;
    localparam int unsigned REQ_ALU1   = 1;
    localparam int unsigned REQ_LOAD   = 2;
    localparam int unsigned REQ_BRANCH = 3;

    typedef logic [WORD_W-1:0] memory_word_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        memory_word_t     value;
    } cdb_t;

    // True when entry a strictly beats entry b: starved first, then older.
    function automatic logic outranks(input logic st_a, input logic [TAG_W-1:0] age_a,
                                      input logic st_b, input logic [TAG_W-1:0] age_b);
        return (st_a && !st_b) || ((st_a == st_b) && (age_a < age_b));
    endfunction

endpackage

// File: rtl/cdb_age_select.sv
// Combinational ranking of held results; picks the two highest-priority slots.
//   hold_valid : occupied holding slots
//   age        : ROB age per slot (smaller is older)
//   starved    : slot has waited long enough to jump the queue
//   grant0_c   : one-hot winner (drives cdb1), zero if nothing held
//   grant1_c   : one-hot runner-up (drives cdb2), zero if fewer than two held
module cdb_age_select
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF
) (
    input  logic [NUM_REQ-1:0]            hold_valid,
    input  logic [NUM_REQ-1:0][TAG_W-1:0] age,
    input  logic [NUM_REQ-1:0]            starved,
    output logic [NUM_REQ-1:0]            grant0_c,
    output logic [NUM_REQ-1:0]            grant1_c
);

    logic             found0, found1;
    logic             st0, st1;
    logic [TAG_W-1:0] age0, age1;

    // Two compare-and-select passes; strict compare keeps the lower index on ties.
    always_comb begin
        grant0_c = '0;
        grant1_c = '0;
        found0   = 1'b0;
        found1   = 1'b0;
        st0      = 1'b0;
        st1      = 1'b0;
        age0     = '0;
        age1     = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (hold_valid[i] && (!found0 || outranks(starved[i], age[i], st0, age0))) begin
                found0      = 1'b1;
                st0         = starved[i];
                age0        = age[i];
                grant0_c    = '0;
                grant0_c[i] = 1'b1;
            end
        end
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (hold_valid[i] && !grant0_c[i] &&
                (!found1 || outranks(starved[i], age[i], st1, age1))) begin
                found1      = 1'b1;
                st1         = starved[i];
                age1        = age[i];
                grant1_c    = '0;
                grant1_c[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Arbitrates FU results onto the two common data buses.
//   clk, reset : clock, asynchronous active-high reset
//   rob_head   : ROB index of the oldest in-flight instruction
//   flush      : squash all held and outgoing results
//   req_*      : per-FU result handshake (valid/tag/value in, ready out, ready is combinational)
//   cdb1, cdb2 : registered broadcast buses, tag 0 = idle
//   pending    : registered count of occupied holding slots
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ      = NUM_REQ_DEF,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int unsigned ROB_SIZE     = ROB_SIZE_DEF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [TAG_W-1:0]               rob_head,
    input  logic                           flush,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0][TAG_W-1:0]  req_tag,
    input  logic [NUM_REQ-1:0][WORD_W-1:0] req_value,
    output logic [NUM_REQ-1:0]             req_ready,
    output cdb_t                           cdb1,
    output cdb_t                           cdb2,
    output logic [TAG_W-1:0]               pending
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [NUM_REQ-1:0]             hold_valid_q, hold_valid_d;
    logic [NUM_REQ-1:0][TAG_W-1:0]  hold_tag_q, hold_tag_d;
    logic [NUM_REQ-1:0][WORD_W-1:0] hold_value_q, hold_value_d;
    logic [NUM_REQ-1:0][CNT_W-1:0]  starve_q, starve_d;
    cdb_t                           cdb1_q, cdb1_d, cdb2_q, cdb2_d;
    logic [TAG_W-1:0]               pending_q, pending_d;

    logic [NUM_REQ-1:0][TAG_W-1:0]  age;
    logic [NUM_REQ-1:0]             starved, grant0, grant1, grant;
    logic [TAG_W-1:0]               idx;

    // ROB age relative to head; tags are 1-based so subtract one first.
    always_comb begin
        idx     = '0;
        age     = '0;
        starved = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            idx = hold_tag_q[i] - TAG_W'(1);
            if (idx >= rob_head) age[i] = idx - rob_head;
            else                 age[i] = idx + TAG_W'(ROB_SIZE) - rob_head;
            starved[i] = (starve_q[i] >= CNT_W'(STARVE_LIMIT));
        end
    end

    cdb_age_select #(.NUM_REQ(NUM_REQ)) u_age_select (
        .hold_valid (hold_valid_q),
        .age        (age),
        .starved    (starved),
        .grant0_c   (grant0),
        .grant1_c   (grant1)
    );

    assign grant = grant0 | grant1;
    // A flush discards this cycle's inputs, so every slot reports ready.
    assign req_ready = ~hold_valid_q | grant | {NUM_REQ{flush}};

    // Slot update, bus muxing and occupancy count.
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_tag_d   = hold_tag_q;
        hold_value_d = hold_value_q;
        starve_d     = starve_q;
        cdb1_d       = '0;
        cdb2_d       = '0;
        pending_d    = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant[i]) begin
                hold_valid_d[i] = 1'b0;
                starve_d[i]     = '0;
            end else if (hold_valid_q[i] && (starve_q[i] < CNT_W'(STARVE_LIMIT))) begin
                starve_d[i] = starve_q[i] + CNT_W'(1);
            end
            // Refill wins over the grant clear; the old data still broadcasts.
            if (req_valid[i] && req_ready[i]) begin
                hold_valid_d[i] = 1'b1;
                hold_tag_d[i]   = req_tag[i];
                hold_value_d[i] = req_value[i];
                starve_d[i]     = '0;
            end
            if (grant0[i]) cdb1_d = '{tag: hold_tag_q[i], value: hold_value_q[i]};
            if (grant1[i]) cdb2_d = '{tag: hold_tag_q[i], value: hold_value_q[i]};
        end
        if (flush) begin
            hold_valid_d = '0;
            starve_d     = '0;
            cdb1_d       = '0;
            cdb2_d       = '0;
        end
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            pending_d = pending_d + TAG_W'(hold_valid_d[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_valid_q <= '0;
            hold_tag_q   <= '0;
            hold_value_q <= '0;
            starve_q     <= '0;
            cdb1_q       <= '0;
            cdb2_q       <= '0;
            pending_q    <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_tag_q   <= hold_tag_d;
            hold_value_q <= hold_value_d;
            starve_q     <= starve_d;
            cdb1_q       <= cdb1_d;
            cdb2_q       <= cdb2_d;
            pending_q    <= pending_d;
        end
    end

    assign cdb1    = cdb1_q;
    assign cdb2    = cdb2_q;
    assign pending = pending_q;

endmodule
